rob_ctrl: RTL
=============

Name: rob_ctrl

Overview:
- In-order allocate / out-of-order writeback / in-order commit controller for the reorder buffer.
- Owns head/tail pointers and per-entry done bits.
- Sequences one mem_2ps instance as result storage: writeback drives the sync write port; the head pointer drives the async read port, which feeds commit data.
- Sits between the issue stage (allocation), the execution units (writeback) and the retire stage (commit).

Parameters:
ID_WIDTH, 4, entry tag width; depth DEPTH = 2**ID_WIDTH
DATA_WIDTH, 8, result payload width

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
alloc_valid_i  in  1  issue requests one entry
alloc_ready_o  out  1  entry available (not full)
alloc_id_o  out  ID_WIDTH  tag granted on alloc handshake (= tail index)
wb_valid_i  in  1  result writeback strobe
wb_id_i  in  ID_WIDTH  tag being written back
wb_data_i  in  DATA_WIDTH  result payload
commit_valid_o  out  1  head entry done, ready to retire
commit_ready_i  in  1  retire stage accepts
commit_id_o  out  ID_WIDTH  head tag
commit_data_o  out  DATA_WIDTH  head result (mem async read)
count_o  out  ID_WIDTH+1  occupied entries, 0..DEPTH
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0

Behaviour:
- State:
  - head and tail pointers, each ID_WIDTH+1 bits; the extra wrap bit distinguishes full from empty.
  - done[DEPTH] bit vector.
  - Memory contents are never reset.
- Reset, asynchronous on rst_n low, applied immediately, mid-operation included:
  - head = tail = 0, done = 0.
  - Outputs: alloc_ready_o=1, alloc_id_o=0, commit_valid_o=0, commit_id_o=0, count_o=0, empty_o=1, full_o=0.
  - Pending transactions are dropped.
- Derived signals:
  - count = tail - head, modulo 2^(ID_WIDTH+1).
  - full when the index bits are equal and the wrap bits differ; empty when pointers are equal.
- Allocation:
  - alloc_ready_o = !full; it does not depend on commit_ready_i (no same-cycle pass-through when full).
  - alloc_id_o = tail[ID_WIDTH-1:0] combinationally.
  - On alloc_valid_i & alloc_ready_o: tail++ and done[tail] <= 0.
- Writeback:
  - Accepted only if wb_id_i lies in the allocated window (pointers as of the start of the cycle) and done[wb_id_i]==0.
  - On accept: mem write (write_en = accept) and done[wb_id_i] <= 1, visible next cycle.
  - Otherwise ignored: no mem write, no state change. This covers an unallocated tag, a tag allocated in the same cycle, and a duplicate writeback.
- Commit:
  - commit_valid_o = !empty & done[head]. commit_id_o = head index; commit_data_o = mem[head] via async read.
  - On commit_valid_o & commit_ready_i: done[head] <= 0, head++.
  - Zero-latency: data written back in cycle N is committable in cycle N+1.
- Simultaneous events:
  - Alloc and commit in the same cycle: count unchanged.
  - Alloc, writeback and commit together are all independent.
- Wrap-around: pointer index wraps DEPTH-1 -> 0 and the wrap bit toggles; full and empty stay correct across the wrap.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- Defined:
  - If an accepted writeback targets the head entry in the same cycle, commit_valid_o=1 and commit_data_o=wb_data_i combinationally.
  - If commit_ready_i is also 1, the entry retires that cycle: done stays 0 and head++. The mem write still occurs.
  - If commit_ready_i is 0, done is set as normal.
- Undefined: no bypass; commit earliest one cycle after writeback.

Decomposition:
- Package rob_pkg:
  - ROB_ID_WIDTH_DEF and ROB_DATA_WIDTH_DEF constants.
  - A function in_window(head, tail, id) returning the allocated-window check, shared with the future flush logic.
- Sub-module: instantiate the existing mem_2ps (ADDR_WIDTH=ID_WIDTH, DATA_WIDTH); no other sub-module.

Test Plan:
- Fill/drain, DEPTH=16: allocate 16 -> ids 0..15, full_o=1 and alloc_ready_o=0 after the 16th; write back all with data=id+8'hA0; commit 16 in order -> data A0..AF, empty_o=1.
- Out-of-order: alloc ids 0,1,2; writeback 2 (0x22), then 0 (0x00), then 1 (0x11):
  - commit_valid_o stays 0 until id 0 is done.
  - Retire order 0,1,2 with data 00,11,22.
- Illegal writeback:
  - With head=tail=3, wb_id_i=5 -> ignored, later allocation of id 5 shows done=0.
  - Duplicate writeback to a done id with 0xFF -> original data retained.
- Wrap plus same-cycle events: run alloc/commit at 1 per cycle for 40 cycles with commit_ready_i=1 -> count_o constant, ids wrap 15->0, no drops.
- Backpressure: head done, commit_ready_i=0 for 5 cycles -> commit_valid_o, commit_id_o and commit_data_o held stable; then ready -> retire once.
- Async reset: assert rst_n=0 mid-stream with count=7 -> outputs at reset values immediately; after release, the first allocation gets id 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared constants and helpers for the reorder-buffer controller.
package rob_pkg;

  localparam int unsigned ROB_ID_WIDTH_DEF   = 4;
  localparam int unsigned ROB_DATA_WIDTH_DEF = 8;

  // Pointers carry one wrap bit above the index; id is an index.
  // True when id lies in [head, tail) modulo the buffer depth.
  function automatic logic in_window(input logic [31:0] head,
                                     input logic [31:0] tail,
                                     input logic [31:0] id,
                                     input int unsigned id_w);
    logic [31:0] idx_mask;
    logic [31:0] ptr_mask;
    logic [31:0] cnt;
    logic [31:0] ofs;
    idx_mask = (32'd1 << id_w) - 32'd1;
    ptr_mask = (idx_mask << 1) | 32'd1;
    cnt      = (tail - head) & ptr_mask;
    ofs      = (id - head) & idx_mask;
    return ofs < cnt;
  endfunction

endpackage

// File: rtl/mem_2ps.sv
// Two-port memory: synchronous write port, asynchronous read port. Contents are not reset.
module mem_2ps #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order alloc, out-of-order writeback, in-order commit.
// Optional ROB_WB_BYPASS_EN forwards a same-cycle writeback to the head straight to commit.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = ROB_ID_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = ROB_DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  output logic [ID_WIDTH-1:0]   alloc_id_o,
  input  logic                  wb_valid_i,
  input  logic [ID_WIDTH-1:0]   wb_id_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [ID_WIDTH-1:0]   commit_id_o,
  output logic [DATA_WIDTH-1:0] commit_data_o,
  output logic [ID_WIDTH:0]     count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned DEPTH = 2**ID_WIDTH;

  logic [ID_WIDTH:0]     head_q, head_d;
  logic [ID_WIDTH:0]     tail_q, tail_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [ID_WIDTH-1:0]   head_idx, tail_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  full, empty;
  logic                  wb_accept, bypass_hit;
  logic                  alloc_fire, commit_fire;

  assign head_idx = head_q[ID_WIDTH-1:0];
  assign tail_idx = tail_q[ID_WIDTH-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[ID_WIDTH] != tail_q[ID_WIDTH]);

  assign wb_accept = wb_valid_i && !done_q[wb_id_i]
                     && in_window(32'(head_q), 32'(tail_q), 32'(wb_id_i), ID_WIDTH);

`ifdef ROB_WB_BYPASS_EN
  assign bypass_hit = wb_accept && (wb_id_i == head_idx);
`else
  assign bypass_hit = 1'b0;
`endif

  assign alloc_ready_o  = !full;
  assign alloc_id_o     = tail_idx;
  assign commit_valid_o = !empty && (done_q[head_idx] || bypass_hit);
  assign commit_id_o    = head_idx;
  assign commit_data_o  = bypass_hit ? wb_data_i : mem_rdata;
  assign count_o        = tail_q - head_q;
  assign full_o         = full;
  assign empty_o        = empty;

  assign alloc_fire  = alloc_valid_i && !full;
  assign commit_fire = commit_valid_o && commit_ready_i;

  // Commit clear is applied last so a bypassed retire leaves the entry not-done.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    if (alloc_fire) begin
      tail_d           = tail_q + 1'b1;
      done_d[tail_idx] = 1'b0;
    end
    if (wb_accept) done_d[wb_id_i] = 1'b1;
    if (commit_fire) begin
      head_d           = head_q + 1'b1;
      done_d[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
    end
  end

  mem_2ps #(
    .ADDR_WIDTH (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wb_accept),
    .waddr_i (wb_id_i),
    .wdata_i (wb_data_i),
    .raddr_i (head_idx),
    .rdata_o (mem_rdata)
  );

endmodule
